zap_tag_ram_inv_mp: RTL
=======================

ZAP_TAG_RAM_INV_MP -- requirements
Module: zap_tag_ram_inv_mp

Interface
REQ-001 SHALL have parameter DEPTH, default 32, entry count; power of two, >= 2.
REQ-002 SHALL have parameter WIDTH, default 32, data bits per entry, excluding valid bit.
REQ-003 SHALL have parameter RD_PORTS, default 2, independent read ports, 1..4; AW = $clog2(DEPTH).
REQ-004 SHALL have i_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have i_reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have i_clken  input  1  clock enable for writes and read pipeline advance.
REQ-007 SHALL have i_wen, i_waddr, i_wdata  input  1/AW/WIDTH  write strobe, address, data.
REQ-008 SHALL have i_inv  input  1  invalidate all entries.
REQ-009 SHALL have i_inv_one, i_inv_addr  input  1/AW  invalidate the single entry at i_inv_addr.
REQ-010 SHALL have i_raddr  input  RD_PORTS*AW  packed read addresses; port p at [p*AW +: AW].
REQ-011 SHALL have o_rdata_pre, o_rdav_pre  output  RD_PORTS*WIDTH/RD_PORTS  stage-1 data/valid per port.
REQ-012 SHALL have o_rdata, o_rdav  output  RD_PORTS*WIDTH/RD_PORTS  stage-2 data/valid per port.
REQ-013 SHALL have o_valid_cnt  output  $clog2(DEPTH+1)  number of currently valid entries.

Function
REQ-014 SHALL store data in an internal flop array with one valid bit per entry; no external RAM.
REQ-015 SHALL write i_wdata to entry i_waddr and set its valid bit at the edge where i_wen && i_clken.
REQ-016 SHALL clear every valid bit at any edge with i_inv=1, regardless of i_clken; data array is not cleared.
REQ-017 SHALL clear valid bit i_inv_addr at any edge with i_inv_one=1, regardless of i_clken.
REQ-018 SHALL prioritise i_inv > i_inv_one > write; same-address write with i_inv_one leaves entry invalid but data written.
REQ-019 SHALL, per port, when i_clken: load stage 1 (o_rdata_pre/o_rdav_pre, address copy) from array at i_raddr; latency 1 cycle.
REQ-020 SHALL, per port, when i_clken: load stage 2 (o_rdata/o_rdav, address copy) from stage 1; latency 2 cycles.
REQ-021 SHALL hold all pipeline stages when i_clken=0, except the invalidation effects of REQ-023/024.
REQ-022 SHALL forward a write (i_wen && i_clken) into any stage whose loaded address equals i_waddr: data=i_wdata, valid=1, same edge.
REQ-023 SHALL clear all o_rdav_pre/o_rdav bits at any edge with i_inv=1.
REQ-024 SHALL clear the valid bit of any stage whose address equals i_inv_addr at an edge with i_inv_one=1, overriding forwarding.
REQ-025 SHALL update o_valid_cnt each edge: 0 on i_inv; else +1 on effective write to invalid entry, -1 on i_inv_one to valid entry.
REQ-026 SHALL apply both count terms when write and i_inv_one target different addresses (net 0 possible); same address: -1 only if previously valid.
REQ-027 SHALL never let o_valid_cnt exceed DEPTH or wrap below 0.
REQ-028 SHALL treat ports identically; multiple ports reading the same address return identical results.

Reset
REQ-029 SHALL, while i_reset_n=0, asynchronously clear all valid bits, o_rdav_pre, o_rdav, o_valid_cnt, and stage address copies to 0.
REQ-030 SHALL reset o_rdata_pre and o_rdata to 0; data array contents are not reset.
REQ-031 SHALL, after deassertion mid-operation, return valid=0 for all in-flight reads and accept writes on the first clocked edge.

Verification
REQ-032 SHALL pass: reset, write A=3 data 0x55, read port0 A=3 next cycle -> o_rdav_pre=1/0x55 at +1, o_rdav=1/0x55 at +2, o_valid_cnt=1.
REQ-033 SHALL pass: read A=5 (invalid) while same-cycle write A=5 0xAA -> o_rdav_pre=1, o_rdata_pre=0xAA next cycle.
REQ-034 SHALL pass: fill all 32 entries -> o_valid_cnt=32; pulse i_inv with i_clken=0 -> count=0, all rdav=0 next edge.
REQ-035 SHALL pass: entries 7 and 9 valid; i_inv_one A=7 with write A=9 same cycle -> count unchanged-1 (=1), read 7 rdav=0, read 9 rdav=1.
REQ-036 SHALL pass: ports 0/1 read A=4 in flight, i_inv_one A=4 while stage 2 loads -> both o_rdav=0 next cycle.
REQ-037 SHALL pass: i_reset_n low mid-stream with pending reads -> all rdav and count=0 immediately, without clock edge.

Source files
------------

// File: rtl/zap_tag_ram_inv_mp.sv
// rtl/zap_tag_ram_inv_mp.sv - flop-based tag RAM with per-entry valid bits, invalidation and
// multi-port two-stage read pipeline with write forwarding
module zap_tag_ram_inv_mp #(
  parameter int DEPTH    = 32,
  parameter int WIDTH    = 32,
  parameter int RD_PORTS = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_clken,
  input  logic                      i_wen,
  input  logic [AW-1:0]             i_waddr,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic                      i_inv,
  input  logic                      i_inv_one,
  input  logic [AW-1:0]             i_inv_addr,
  input  logic [RD_PORTS*AW-1:0]    i_raddr,
  output logic [RD_PORTS*WIDTH-1:0] o_rdata_pre,
  output logic [RD_PORTS-1:0]       o_rdav_pre,
  output logic [RD_PORTS*WIDTH-1:0] o_rdata,
  output logic [RD_PORTS-1:0]       o_rdav,
  output logic [CW-1:0]             o_valid_cnt
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_cnt;
  logic             w_wr;
  logic             w_inc;
  logic             w_dec;

  assign w_wr = i_wen & i_clken;

  // A same-address invalidate wins over the write, so the write never adds a valid entry then.
  assign w_inc = w_wr && !r_valid[i_waddr] && !(i_inv_one && (i_inv_addr == i_waddr));
  assign w_dec = i_inv_one && r_valid[i_inv_addr];

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else if (i_inv) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_wr) r_valid[i_waddr] <= 1'b1;
      if (i_inv_one) r_valid[i_inv_addr] <= 1'b0;
      r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  assign o_valid_cnt = r_cnt;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [AW-1:0]    w_ra;
    logic [AW-1:0]    w_s1_na;
    logic [AW-1:0]    w_s2_na;
    logic             w_hit1;
    logic             w_hit2;
    logic [AW-1:0]    r_s1_addr;
    logic [AW-1:0]    r_s2_addr;
    logic [WIDTH-1:0] r_s1_data;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s1_v;
    logic             r_s2_v;

    assign w_ra    = i_raddr[p*AW +: AW];
    // Address each stage will hold after this edge; invalidation matches against it.
    assign w_s1_na = i_clken ? w_ra : r_s1_addr;
    assign w_s2_na = i_clken ? r_s1_addr : r_s2_addr;
    assign w_hit1  = w_wr && (w_ra == i_waddr);
    assign w_hit2  = w_wr && (r_s1_addr == i_waddr);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_s1_addr <= '0;
        r_s2_addr <= '0;
        r_s1_data <= '0;
        r_s2_data <= '0;
        r_s1_v    <= 1'b0;
        r_s2_v    <= 1'b0;
      end else begin
        if (i_clken) begin
          r_s1_addr <= w_ra;
          r_s1_data <= w_hit1 ? i_wdata : r_mem[w_ra];
          r_s1_v    <= w_hit1 | r_valid[w_ra];
          r_s2_addr <= r_s1_addr;
          r_s2_data <= w_hit2 ? i_wdata : r_s1_data;
          r_s2_v    <= w_hit2 | r_s1_v;
        end
        if (i_inv) begin
          r_s1_v <= 1'b0;
          r_s2_v <= 1'b0;
        end else if (i_inv_one) begin
          if (w_s1_na == i_inv_addr) r_s1_v <= 1'b0;
          if (w_s2_na == i_inv_addr) r_s2_v <= 1'b0;
        end
      end
    end

    assign o_rdata_pre[p*WIDTH +: WIDTH] = r_s1_data;
    assign o_rdata[p*WIDTH +: WIDTH]     = r_s2_data;
    assign o_rdav_pre[p]                 = r_s1_v;
    assign o_rdav[p]                     = r_s2_v;
  end

endmodule
